// File: rtl/pg_carry_resolver.sv
// Pipelined carry resolver: consumes per-bit propagate/generate plus carry-in, resolves one BLOCK-bit slice per stage.
// Optional zero flag output enabled by defining PGCR_ZERO_FLAG_EN.
module pg_carry_resolver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef PGCR_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned NUM_STAGES = WIDTH / BLOCK;

    logic [WIDTH-1:0]      st_p [NUM_STAGES];
    logic [WIDTH-1:0]      st_g [NUM_STAGES];
    logic [WIDTH-1:0]      st_s [NUM_STAGES];
    logic [NUM_STAGES-1:0] st_v;
    logic [NUM_STAGES-1:0] st_c;
    logic                  st_ovf;

    logic [WIDTH-1:0]      src_p [NUM_STAGES];
    logic [WIDTH-1:0]      src_g [NUM_STAGES];
    logic [WIDTH-1:0]      src_s [NUM_STAGES];
    logic [NUM_STAGES-1:0] src_v;
    logic [NUM_STAGES-1:0] src_c;

    logic [WIDTH-1:0]      nx_s [NUM_STAGES];
    logic [NUM_STAGES-1:0] nx_c;
    logic                  msb_c;
    logic [NUM_STAGES:0]   adv;

    // Stage k is fed by stage k-1; stage 0 is fed directly by the input port.
    always_comb begin
        src_p[0] = p_in;
        src_g[0] = g_in;
        src_s[0] = '0;
        src_v[0] = in_valid;
        src_c[0] = cin;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            src_p[k] = st_p[k-1];
            src_g[k] = st_g[k-1];
            src_s[k] = st_s[k-1];
            src_v[k] = st_v[k-1];
            src_c[k] = st_c[k-1];
        end
    end

    always_comb begin
        logic [WIDTH-1:0] ss;
        logic             c;
        int unsigned      idx;
        msb_c = 1'b0;
        ss    = '0;
        c     = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            ss = src_s[k];
            c  = src_c[k];
            for (int unsigned i = 0; i < BLOCK; i++) begin
                idx     = k * BLOCK + i;
                ss[idx] = src_p[k][idx] ^ c;
                if (idx == WIDTH - 1)
                    msb_c = c;
                // Generate dominates, so an illegal p=g=1 bit still carries out.
                c = src_g[k][idx] | (src_p[k][idx] & c);
            end
            nx_s[k] = ss;
            nx_c[k] = c;
        end
    end

    // A stage may load when it is empty or its successor takes its contents this cycle.
    always_comb begin
        int unsigned k;
        k = 0;
        adv[NUM_STAGES] = out_ready;
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            k      = NUM_STAGES - 1 - j;
            adv[k] = !st_v[k] || adv[k+1];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = st_v[NUM_STAGES-1];
    assign sum       = st_s[NUM_STAGES-1];
    assign cout      = st_c[NUM_STAGES-1];
    assign ovf       = st_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v   <= '0;
            st_c   <= '0;
            st_ovf <= 1'b0;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                st_p[k] <= '0;
                st_g[k] <= '0;
                st_s[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (adv[k]) begin
                    st_v[k] <= src_v[k];
                    if (src_v[k]) begin
                        st_p[k] <= src_p[k];
                        st_g[k] <= src_g[k];
                        st_s[k] <= nx_s[k];
                        st_c[k] <= nx_c[k];
                    end
                end
            end
            if (adv[NUM_STAGES-1] && src_v[NUM_STAGES-1])
                st_ovf <= msb_c ^ nx_c[NUM_STAGES-1];
        end
    end

`ifdef PGCR_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            zero <= 1'b0;
        else if (adv[NUM_STAGES-1] && src_v[NUM_STAGES-1])
            zero <= (nx_s[NUM_STAGES-1] == '0);
    end
`endif

endmodule
